alu_rv32i: RTL and testbench
============================

# alu_rv32i

Registered 32-bit integer ALU for the RV32I datapath, placed in the execute stage between the operand muxes and the writeback/branch logic. It performs add, subtract, shifts, signed and unsigned set-less-than, and bitwise logic, selected by a 4-bit code. It also produces a zero flag for branch resolution. Result and flags are captured in output registers, giving one cycle of latency.

## Interface
Parameters:
- none. Width is fixed at 32 bits.

Ports:
- clk  in  1  single system clock, rising-edge active
- rst  in  1  reset, asynchronous, active-high
- valid_in  in  1  operands and sel are valid this cycle
- a  in  32  operand A
- b  in  32  operand B; shift amount is b[4:0]
- sel  in  4  operation select
- Y  out  32  registered result
- zero  out  1  registered flag, 1 when Y == 0
- valid_out  out  1  Y and zero were updated by the last edge
- ovf  out  1  registered signed-overflow flag; present only with ALU_OVF_EN

## Operation
sel decode (x = don't care, decoded identically for 0 and 1):
- 0000: a + b, modulo 2^32
- 0001: a − b, modulo 2^32
- 001x: a << b[4:0], logical
- 010x: {31'b0, ($signed(a) < $signed(b))}
- 011x: {31'b0, (a < b)}, unsigned
- 100x: a ^ b
- 1010: a >> b[4:0], logical, zero fill
- 1011: $signed(a) >>> b[4:0], arithmetic, sign fill
- 110x: a | b
- 111x: a & b

Shift and zero rules:
- b[31:5] are ignored for all shifts.
- Shift by 0 returns a unchanged.
- zero is computed from the same-cycle result and registered together with Y.

## Timing
- Reset (rst=1, takes effect immediately and asynchronously): Y = 0, zero = 1, valid_out = 0, ovf = 0.
- On a rising edge with valid_in = 1: Y, zero (and ovf) load the new result; valid_out = 1.
- On a rising edge with valid_in = 0: Y, zero and ovf hold their values; valid_out = 0.
- Latency is one cycle. Throughput is one operation per cycle, with no back-pressure.
- If reset asserts mid-stream, any in-flight result is discarded. The first valid_in after rst deasserts produces valid_out on the next edge.
- Reset deassertion has no effect on the edge where rst is still sampled high.

## Configuration
- ALU_OVF_EN defined:
  - Adds the ovf port.
  - For 0000, ovf = (a[31] == b[31]) && (sum[31] != a[31]).
  - For 0001, ovf = (a[31] != b[31]) && (diff[31] != a[31]).
  - For all other sel, ovf = 0.
  - ovf is registered with the same valid_in/reset rules as Y.
- ALU_OVF_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Add, subtract and zero flag: a=3, b=6, sel=0000 -> Y=9, zero=0, one cycle later. sel=0001 -> Y=0xFFFFFFFD. a=3, b=3, sel=0001 -> Y=0, zero=1.
- Shift left and set-less-than: a=3, b=6, sel=0010 and sel=0011 -> Y=0xC0. sel=0100/0101 -> Y=1. sel=0110/0111 -> Y=1. a=0xFFFFFFFF, b=1: sel=0100 -> 1, sel=0110 -> 0.
- Logic ops: a=3, b=6: sel=1000 -> 5; sel=1100 -> 7; sel=1110 -> 2; each with zero=0.
- Right shifts: a=0x80000000, b=4: sel=1010 -> 0x08000000; sel=1011 -> 0xF8000000. b=0x24 -> shift by 4, same results.
- Valid, hold and reset:
  - valid_in=0 after a result -> Y holds and valid_out=0.
  - Assert rst asynchronously between edges -> Y=0, zero=1, valid_out=0 immediately.
- Overflow (ALU_OVF_EN):
  - a=0x7FFFFFFF, b=1, sel=0000 -> Y=0x80000000, ovf=1.
  - a=0x80000000, b=1, sel=0001 -> ovf=1.
  - a=3, b=6, sel=0000 -> ovf=0.

Source files
------------

// File: rtl/alu_rv32i.sv
// rtl/alu_rv32i.sv - registered RV32I execute-stage ALU with zero flag
// Optional signed-overflow output enabled by defining ALU_OVF_EN.
module alu_rv32i (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  sel,
  output logic [31:0] Y,
  output logic        zero,
  output logic        valid_out
`ifdef ALU_OVF_EN
  ,
  output logic        ovf
`endif
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  shamt;
  logic [31:0] res;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[4:0];

  always_comb begin
    res = '0;
    casez (sel)
      4'b0000: res = sum;
      4'b0001: res = diff;
      4'b001?: res = a << shamt;
      4'b010?: res = {31'b0, ($signed(a) < $signed(b))};
      4'b011?: res = {31'b0, (a < b)};
      4'b100?: res = a ^ b;
      4'b1010: res = a >> shamt;
      4'b1011: res = $signed(a) >>> shamt;
      4'b110?: res = a | b;
      4'b111?: res = a & b;
      default: res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic ovf_n;

  always_comb begin
    ovf_n = 1'b0;
    if (sel == 4'b0000)
      ovf_n = (a[31] == b[31]) && (sum[31] != a[31]);
    else if (sel == 4'b0001)
      ovf_n = (a[31] != b[31]) && (diff[31] != a[31]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf <= 1'b0;
    else if (valid_in)
      ovf <= ovf_n;
  end
`endif

  // Y and zero hold across idle cycles; only valid_out tracks valid_in every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y         <= '0;
      zero      <= 1'b1;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        Y    <= res;
        zero <= (res == 32'd0);
      end
    end
  end

endmodule

// File: tb/tb_alu_rv32i.sv
// tb/tb_alu_rv32i.sv - directed self-checking bench for alu_rv32i
// Overflow checks are included when ALU_OVF_EN is defined.
module tb_alu_rv32i;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  sel;
  logic [31:0] Y;
  logic        zero;
  logic        valid_out;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  alu_rv32i dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .Y         (Y),
    .zero      (zero),
    .valid_out (valid_out)
`ifdef ALU_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one valid operation, then check Y/zero/valid_out one edge later.
  task automatic op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                    input logic [3:0] tsel, input logic [31:0] exp_y);
    a        = ta;
    b        = tb;
    sel      = tsel;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".Y"}, Y, exp_y);
    check({tag, ".zero"}, {31'b0, zero}, {31'b0, (exp_y == 32'd0)});
    check({tag, ".valid_out"}, {31'b0, valid_out}, 32'd1);
  endtask

  initial begin
    rst      = 1'b0;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    sel      = '0;
    #2 rst = 1'b1;
    #1;
    check("reset.Y", Y, 32'd0);
    check("reset.zero", {31'b0, zero}, 32'd1);
    check("reset.valid_out", {31'b0, valid_out}, 32'd0);
`ifdef ALU_OVF_EN
    check("reset.ovf", {31'b0, ovf}, 32'd0);
`endif
    valid_in = 1'b1;
    a = 32'd3; b = 32'd6; sel = 4'b0000;
    @(posedge clk);
    #1;
    check("rst_edge.valid_out", {31'b0, valid_out}, 32'd0);
    check("rst_edge.Y", Y, 32'd0);
    rst = 1'b0;

    op("add",      32'd3, 32'd6, 4'b0000, 32'd9);
    op("sub",      32'd3, 32'd6, 4'b0001, 32'hFFFF_FFFD);
    op("sub_zero", 32'd3, 32'd3, 4'b0001, 32'd0);
    op("sll0",     32'd3, 32'd6, 4'b0010, 32'h0000_00C0);
    op("sll1",     32'd3, 32'd6, 4'b0011, 32'h0000_00C0);
    op("sll_by0",  32'h1234_5678, 32'h0000_0020, 4'b0010, 32'h1234_5678);
    op("slt0",     32'd3, 32'd6, 4'b0100, 32'd1);
    op("slt1",     32'd3, 32'd6, 4'b0101, 32'd1);
    op("sltu0",    32'd3, 32'd6, 4'b0110, 32'd1);
    op("sltu1",    32'd3, 32'd6, 4'b0111, 32'd1);
    op("slt_neg",  32'hFFFF_FFFF, 32'd1, 4'b0100, 32'd1);
    op("sltu_big", 32'hFFFF_FFFF, 32'd1, 4'b0110, 32'd0);
    op("xor",      32'd3, 32'd6, 4'b1000, 32'd5);
    op("or",       32'd3, 32'd6, 4'b1100, 32'd7);
    op("and",      32'd3, 32'd6, 4'b1110, 32'd2);
    op("and1",     32'd3, 32'd6, 4'b1111, 32'd2);
    op("srl",      32'h8000_0000, 32'd4, 4'b1010, 32'h0800_0000);
    op("sra",      32'h8000_0000, 32'd4, 4'b1011, 32'hF800_0000);
    op("srl_hi",   32'h8000_0000, 32'h24, 4'b1010, 32'h0800_0000);
    op("sra_hi",   32'h8000_0000, 32'h24, 4'b1011, 32'hF800_0000);

    valid_in = 1'b0;
    a = 32'd0; b = 32'd0; sel = 4'b0000;
    @(posedge clk);
    #1;
    check("hold.Y", Y, 32'hF800_0000);
    check("hold.zero", {31'b0, zero}, 32'd0);
    check("hold.valid_out", {31'b0, valid_out}, 32'd0);

`ifdef ALU_OVF_EN
    op("ovf_add", 32'h7FFF_FFFF, 32'd1, 4'b0000, 32'h8000_0000);
    check("ovf_add.ovf", {31'b0, ovf}, 32'd1);
    op("ovf_sub", 32'h8000_0000, 32'd1, 4'b0001, 32'h7FFF_FFFF);
    check("ovf_sub.ovf", {31'b0, ovf}, 32'd1);
    op("ovf_none", 32'd3, 32'd6, 4'b0000, 32'd9);
    check("ovf_none.ovf", {31'b0, ovf}, 32'd0);
    op("ovf_other", 32'h7FFF_FFFF, 32'd1, 4'b1100, 32'h7FFF_FFFF);
    check("ovf_other.ovf", {31'b0, ovf}, 32'd0);
`endif

    op("pre_rst", 32'd3, 32'd6, 4'b0000, 32'd9);
    a = 32'd5; b = 32'd5; sel = 4'b1100; valid_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst.Y", Y, 32'd0);
    check("async_rst.zero", {31'b0, zero}, 32'd1);
    check("async_rst.valid_out", {31'b0, valid_out}, 32'd0);
    @(posedge clk);
    #1;
    check("in_rst.valid_out", {31'b0, valid_out}, 32'd0);
    check("in_rst.Y", Y, 32'd0);
    rst = 1'b0;
    op("post_rst", 32'd5, 32'd5, 4'b1100, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
